// File: rtl/fml_wbuf.sv
// fml_wbuf: posted-write buffer between the Wishbone-to-FML bridge and an FML slave.
// Writes are acknowledged as soon as they land in a small FIFO and are drained
// downstream in order. Reads wait until the FIFO is empty, which preserves
// read-after-write ordering without any forwarding logic.
module fml_wbuf #(
    parameter int fml_depth  = 25,
    parameter int depth_log2 = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,

    input  logic [fml_depth-1:0] s_adr,
    input  logic                 s_stb,
    input  logic                 s_we,
    input  logic [3:0]           s_sel,
    input  logic [31:0]          s_wdat,
    output logic                 s_ack,
    output logic [31:0]          s_rdat,

    output logic [fml_depth-1:0] m_adr,
    output logic                 m_stb,
    output logic                 m_we,
    output logic [3:0]           m_sel,
    output logic [31:0]          m_wdat,
    input  logic                 m_ack,
    input  logic [31:0]          m_rdat,

    output logic                 idle
);

    localparam int ENTRIES = 1 << depth_log2;
    localparam logic [depth_log2:0] FULL_COUNT = (depth_log2 + 1)'(ENTRIES);

    typedef enum logic [1:0] {
        IDLE,
        WDRAIN,
        READ,
        RACK
    } state_t;

    state_t state;

    // Write FIFO storage: one entry is {adr, sel, wdat}.
    logic [fml_depth-1:0] fifo_adr  [ENTRIES];
    logic [3:0]           fifo_sel  [ENTRIES];
    logic [31:0]          fifo_wdat [ENTRIES];

    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2:0]   count;

    logic full;
    logic push;
    logic pop;

    // Acceptance looks only at the registered count, so a pop in the same
    // cycle never unblocks a write to a full FIFO. The ~s_ack term makes the
    // master's still-asserted strobe during its ack cycle harmless.
    assign full = (count == FULL_COUNT);
    assign push = s_stb & s_we & ~s_ack & ~full;
    assign pop  = (state == WDRAIN) & m_ack;

    // FIFO payload; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_adr[wr_ptr]  <= s_adr;
            fifo_sel[wr_ptr]  <= s_sel;
            fifo_wdat[wr_ptr] <= s_wdat;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at 2^depth_log2.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Downstream sequencer with all upstream/downstream outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            m_adr  <= '0;
            m_stb  <= 1'b0;
            m_we   <= 1'b0;
            m_sel  <= '0;
            m_wdat <= '0;
            s_ack  <= 1'b0;
            s_rdat <= '0;
            idle   <= 1'b1;
        end else begin
            // Write acks follow acceptance by one cycle; the read path
            // overrides this when its data returns.
            s_ack <= push;
            idle  <= (count == '0) && (state == IDLE);

            case (state)
                IDLE: begin
                    // Buffered writes always go first; a read only starts
                    // once nothing is left to drain.
                    if (count != '0) begin
                        m_adr  <= fifo_adr[rd_ptr];
                        m_sel  <= fifo_sel[rd_ptr];
                        m_wdat <= fifo_wdat[rd_ptr];
                        m_we   <= 1'b1;
                        m_stb  <= 1'b1;
                        state  <= WDRAIN;
                    end else if (s_stb && !s_we && !s_ack) begin
                        // sel/wdat are don't-care for reads but mirroring
                        // the upstream keeps them stable for the slave.
                        m_adr  <= s_adr;
                        m_sel  <= s_sel;
                        m_wdat <= s_wdat;
                        m_we   <= 1'b0;
                        m_stb  <= 1'b1;
                        state  <= READ;
                    end
                end

                WDRAIN: begin
                    // Request held stable until the slave takes it; the
                    // return through IDLE leaves a gap between transfers.
                    if (m_ack) begin
                        m_stb <= 1'b0;
                        state <= IDLE;
                    end
                end

                READ: begin
                    if (m_ack) begin
                        s_rdat <= m_rdat;
                        s_ack  <= 1'b1;
                        m_stb  <= 1'b0;
                        state  <= RACK;
                    end
                end

                RACK: begin
                    // s_ack is high during this state for exactly one cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the buffer and its handshakes.
    a_count_bound: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        count <= FULL_COUNT);

    a_pop_nonempty: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        pop |-> (count != '0));

    a_drain_hold: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (state == WDRAIN && !m_ack) |=>
            (m_stb && $stable(m_adr) && $stable(m_sel) && $stable(m_wdat)));

    a_ack_pulse: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        s_ack |=> !s_ack);

endmodule

// File: doc/fml_wbuf.md
Name: fml_wbuf

Overview:
- Posted-write buffer between the Wishbone-to-FML bypass bridge (upstream) and the FML slave port: memory controller or arbiter (downstream).
- Upstream writes are acknowledged as soon as they enter a small FIFO, then drained to FML in order.
- Reads are forwarded only after all buffered writes have completed, which preserves read-after-write ordering.
- Gives the CPU single-cycle write acknowledge without changing the bridge.

Parameters:
- fml_depth, 25: FML address width in bits.
- depth_log2, 2: log2 of FIFO entry count (default 4 entries).

Ports:
- sys_clk      in   1          system clock
- sys_rst_n    in   1          reset, asynchronous assert, active-low
- s_adr        in   fml_depth  upstream address
- s_stb        in   1          upstream request
- s_we         in   1          upstream write enable
- s_sel        in   4          upstream byte enables
- s_wdat       in   32         upstream write data
- s_ack        out  1          upstream acknowledge, one-cycle pulse
- s_rdat       out  32         upstream read data, valid while s_ack=1 for reads
- m_adr        out  fml_depth  downstream address
- m_stb        out  1          downstream request
- m_we         out  1          downstream write enable
- m_sel        out  4          downstream byte enables
- m_wdat       out  32         downstream write data
- m_ack        in   1          downstream acknowledge, one-cycle pulse
- m_rdat       in   32         downstream read data, valid with m_ack
- idle         out  1          FIFO empty and FSM in IDLE (used as flush-done)

Behaviour:
- Clock and reset: single clock domain sys_clk; sys_rst_n is asynchronous and active-low.
- Reset values: all outputs registered and reset to 0, except idle, which resets to 1. FIFO pointers and count reset to 0, FSM to IDLE.
- FIFO storage:
  - Entries hold {adr, sel, wdat}.
  - count has width depth_log2+1; full = (count == 2^depth_log2).
  - Pointers wrap modulo 2^depth_log2.
- Write accept condition, at cycle N: s_stb & s_we & ~s_ack & ~full.
  - Entry is written at the end of N.
  - s_ack=1 during N+1 only.
  - During N+1 s_stb may still be high; it is ignored because s_ack=1.
- Full FIFO: the write is not accepted and s_ack stays 0. Acceptance is evaluated on the registered count; a pop in the same cycle does not unblock it.
- Simultaneous push and pop: count unchanged; both pointers advance.
- FSM states: IDLE, WDRAIN, READ, RACK.
  - IDLE -> WDRAIN when count != 0. Load m_adr/m_sel/m_wdat from the FIFO head, m_we=1, m_stb=1 in the next cycle. A write enqueued at N into an empty FIFO gives m_stb=1 at N+2.
  - WDRAIN: hold m_stb and all m_* signals stable until m_ack=1. On m_ack, pop the head, m_stb=0 in the next cycle, return to IDLE. There is at least one idle cycle between downstream transfers.
  - IDLE -> READ when s_stb & ~s_we & ~s_ack & count==0. Reads have lower priority than a non-empty FIFO. m_adr=s_adr, m_sel=s_sel, m_we=0, m_stb=1 from the next cycle.
  - READ: on m_ack, capture m_rdat into s_rdat, m_stb=0, go to RACK.
  - RACK: s_ack=1 for one cycle, then IDLE.
  - Read latency: s_ack at the cycle after m_ack. s_rdat holds its value until the next read capture.
- Read pending while the FIFO is non-empty: wait in IDLE/WDRAIN until drained. No forwarding from buffered writes.
- m_wdat and m_sel are don't-care for reads but are driven from s_* to keep them stable.
- idle = (count==0) & (state==IDLE), registered.
- Reset mid-transfer: buffered writes are discarded, m_stb drops immediately (asynchronously), and any pending s_ack is lost.

Test Plan:
- Single write: adr=0x000100, wdat=0xDEADBEEF, sel=0xF, s_stb at N -> s_ack=1 at N+1 only; m_stb=1,m_we=1 at N+2 with same adr/dat; m_ack after 3 cycles -> m_stb=0 next cycle, idle=1 one cycle later.
- Fill: 5 back-to-back writes with m_ack held 0 -> first 4 acked, 5th s_ack stays 0; pulse m_ack once -> 5th acked within 2 cycles; drain order on m_adr matches issue order.
- Read after write: write 0x12345678 to 0x40 then read 0x40 -> read m_stb (m_we=0) issued only after write m_ack; m_rdat=0x12345678 returned on s_rdat with s_ack the cycle after m_ack.
- Read on empty FIFO: s_stb read at N -> m_stb at N+1; m_ack at N+4 with m_rdat=0xCAFEF00D -> s_ack and s_rdat=0xCAFEF00D at N+5.
- Pointer wrap: 10 writes with immediate m_ack -> all 10 appear on m_* in order with correct data; count never exceeds 4.
- Reset mid-operation: 3 writes buffered, m_stb high, assert sys_rst_n=0 -> m_stb, s_ack=0 immediately; after release idle=1 and no m_stb ever issued for the discarded entries.
